aes128_encrypt_iter: RTL and testbench

Iterative AES-128 encryption core: accepts a 128-bit plaintext block and 128-bit cipher key over a valid/ready handshake, runs one cipher round per clock with an on-the-fly key schedule, and returns the ciphertext over a second valid/ready handshake. It is the forward-direction counterpart of the decryption round datapath. It composes the forward SubBytes, ShiftRows, MixColumns and AddRoundKey functions with one round-key expansion step.

---
 rtl/aes128_encrypt_iter.sv | 160 ++++++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock, round keys
// expanded on the fly alongside the state update.
module aes128_encrypt_iter (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy
);
   // state | meaning: IDLE accept block | ROUND one round per clock | DONE hold result
   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = ~{b, 3'b000};
      return SBOX_TBL[idx -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 4; i++) o[32*i +: 32] = sub_word(s[32*i +: 32]);
      return o;
   endfunction

   // Row r of column c takes the byte from column (c+r) mod 4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 4; i++) o[32*i +: 32] = mix_col(s[32*i +: 32]);
      return o;
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [127:0]  st_q, st_d;
   logic [127:0]  rk_q, rk_d;
   logic [3:0]    rnd_q, rnd_d;
   logic [127:0]  rk_next;
   logic [127:0]  sr_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         st_q    <= '0;
         rk_q    <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         rk_q    <= rk_d;
         rnd_q   <= rnd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      st_d     = st_q;
      rk_d     = rk_q;
      rnd_d    = rnd_q;
      rk_next  = key_expand(rk_q, rcon(rnd_q));
      sr_state = shift_rows(sub_bytes(st_q));
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_d    = plaintext ^ key;
               rk_d    = key;
               rnd_d   = 4'd1;
               state_d = ROUND;
            end
         end
         ROUND: begin
            rk_d = rk_next;
            if (rnd_q == 4'd10) begin
               st_d    = sr_state ^ rk_next;
               state_d = DONE;
            end else begin
               st_d  = mix_columns(sr_state) ^ rk_next;
               rnd_d = rnd_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q == ROUND) || (state_q == DONE);
   assign ciphertext = st_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed and randomised checks of aes128_encrypt_iter against FIPS-197
// vectors and an independent byte-oriented AES model.
`timescale 1ns/1ps
module tb_aes128_encrypt_iter;
   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  plaintext;
   logic [127:0]  key;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  ciphertext;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] sbox_m [256];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   aes128_encrypt_iter dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference model: S-box derived from the GF(2^8) inverse plus affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] pt);
      logic [7:0] w [176];
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] tmp [4];
      logic [7:0] rc, t0, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         w[i] = k[127-8*i -: 8];
         s[i] = pt[127-8*i -: 8] ^ w[i];
      end
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
         if (i % 4 == 0) begin
            t0 = tmp[0];
            tmp[0] = sbox_m[tmp[1]] ^ rc;
            tmp[1] = sbox_m[tmp[2]];
            tmp[2] = sbox_m[tmp[3]];
            tmp[3] = sbox_m[t0];
            rc = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
      end
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rd+i];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Pushes one block through; entered and left just after a rising edge.
   task automatic do_block(input logic [127:0] k, input logic [127:0] pt, input int stall,
                           output logic [127:0] ct, output int lat, output bit ok);
      bit acc_seen;
      key = k; plaintext = pt; in_valid = 1'b1;
      out_ready = (stall == 0);
      acc_seen = 1'b0; lat = -1; ct = '0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (in_ready) begin acc_seen = 1'b1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin lat = i; break; end
      end
      ct = ciphertext;
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      ok = acc_seen && (lat >= 0);
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      key = 128'hdeadbeef; plaintext = 128'hcafef00d;
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_err++; $display("FAIL reset_flags: got in_ready/out_valid/busy=%b want 100", {in_ready, out_valid, busy});
      end
      n_cmp++;
      if (ciphertext !== 128'h0) begin
         n_err++; $display("FAIL reset_ct: got %h want 0", ciphertext);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (dut.rk_q !== 128'h0 || dut.rnd_q !== 4'd0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_regs: got rk=%h rnd=%0d in_ready=%b want 0 0 1", dut.rk_q, dut.rnd_q, in_ready);
      end
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fips_c1();
      key = C1_KEY; plaintext = C1_PT; out_ready = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL c1_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i <= 11; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== (i == 10)) begin
            n_err++; $display("FAIL c1_out_valid_e%0d: got %b want %b", i, out_valid, (i == 10));
         end
         if (i == 0) begin
            n_cmp++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
               n_err++; $display("FAIL c1_busy: got busy=%b in_ready=%b want 1 0", busy, in_ready);
            end
         end
         if (i == 10) begin
            n_cmp++;
            if (ciphertext !== C1_CT) begin n_err++; $display("FAIL c1_ct: got %h want %h", ciphertext, C1_CT); end
         end
         if (i == 11) begin
            n_cmp++;
            if (in_ready !== 1'b1 || busy !== 1'b0) begin
               n_err++; $display("FAIL c1_return_idle: got in_ready=%b busy=%b want 1 0", in_ready, busy);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_appendix_b();
      logic [127:0] ct; int lat; bit ok;
      do_block(B_KEY, B_PT, 0, ct, lat, ok);
      n_cmp++;
      if (!ok || lat != 10) begin n_err++; $display("FAIL b_latency: got ok=%0d lat=%0d want 1 10", ok, lat); end
      n_cmp++;
      if (ct !== B_CT) begin n_err++; $display("FAIL b_ct: got %h want %h", ct, B_CT); end
      n_cmp++;
      if (dut.rk_q !== B_RK10) begin n_err++; $display("FAIL b_rk10: got %h want %h", dut.rk_q, B_RK10); end
   endtask

   task automatic test_backpressure();
      bit seen;
      key = B_KEY; plaintext = B_PT; out_ready = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      key = C1_KEY; plaintext = C1_PT;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1'b1; break; end
      end
      n_cmp++;
      if (!seen) begin n_err++; $display("FAIL bp_out_valid_timeout: got 0 want 1"); end
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || ciphertext !== B_CT || in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_hold_%0d: got ov=%b ir=%b ct=%h want 1 0 %h", i, out_valid, in_ready, ciphertext, B_CT);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL bp_next_accept: got busy=%b want 1", busy); end
      in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      n_cmp++;
      if (!seen || ciphertext !== C1_CT) begin
         n_err++; $display("FAIL bp_second_ct: got %h want %h", ciphertext, C1_CT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [127:0] bk [3];
      logic [127:0] bp [3];
      logic [127:0] cts [3];
      int acc [3];
      int n_acc, n_ct;
      bit acc_now;
      bk[0] = C1_KEY; bp[0] = C1_PT;
      bk[1] = B_KEY;  bp[1] = B_PT;
      bk[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0; bp[2] = 128'hffeeddccbbaa99887766554433221100;
      n_acc = 0; n_ct = 0;
      for (int i = 0; i < 3; i++) begin acc[i] = 0; cts[i] = '0; end
      key = bk[0]; plaintext = bp[0]; in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         acc_now = in_valid && in_ready;
         if (acc_now && n_acc < 3) begin acc[n_acc] = cyc; n_acc++; end
         if (out_valid && n_ct < 3) begin cts[n_ct] = ciphertext; n_ct++; end
         @(posedge clk); #1;
         if (acc_now) begin
            if (n_acc < 3) begin key = bk[n_acc]; plaintext = bp[n_acc]; end
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      n_cmp++;
      if (n_acc != 3 || n_ct != 3) begin
         n_err++; $display("FAIL b2b_counts: got acc=%0d ct=%0d want 3 3", n_acc, n_ct);
      end
      for (int i = 1; i < 3; i++) begin
         n_cmp++;
         if (acc[i] - acc[i-1] != 12) begin
            n_err++; $display("FAIL b2b_spacing_%0d: got %0d want 12", i, acc[i] - acc[i-1]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (cts[i] !== aes_model(bk[i], bp[i])) begin
            n_err++; $display("FAIL b2b_ct_%0d: got %h want %h", i, cts[i], aes_model(bk[i], bp[i]));
         end
      end
   endtask

   task automatic test_reset_mid_round();
      logic [127:0] ct; int lat; bit ok;
      key = B_KEY; plaintext = B_PT; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      n_cmp++;
      if (busy !== 1'b1 || dut.rnd_q !== 4'd5) begin
         n_err++; $display("FAIL mid_pre: got busy=%b rnd=%0d want 1 5", busy, dut.rnd_q);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({busy, out_valid, in_ready} !== 3'b001 || dut.rnd_q !== 4'd0 || ciphertext !== 128'h0) begin
         n_err++; $display("FAIL mid_async_reset: got busy/ov/ir=%b rnd=%0d ct=%h want 001 0 0",
                           {busy, out_valid, in_ready}, dut.rnd_q, ciphertext);
      end
      #1 reset = 1'b0;
      do_block(C1_KEY, C1_PT, 0, ct, lat, ok);
      n_cmp++;
      if (!ok || lat != 10 || ct !== C1_CT) begin
         n_err++; $display("FAIL mid_rerun: got ok=%0d lat=%0d ct=%h want 1 10 %h", ok, lat, ct, C1_CT);
      end
   endtask

   task automatic test_random();
      logic [127:0] k, pt, ct, exp_ct; int lat, stall; bit ok;
      for (int n = 0; n < 1000; n++) begin
         k  = {$urandom(), $urandom(), $urandom(), $urandom()};
         pt = {$urandom(), $urandom(), $urandom(), $urandom()};
         stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
         do_block(k, pt, stall, ct, lat, ok);
         exp_ct = aes_model(k, pt);
         n_cmp++;
         if (!ok || lat != 10 || ct !== exp_ct) begin
            n_err++; $display("FAIL rand_%0d: got ok=%0d lat=%0d ct=%h want 1 10 %h", n, ok, lat, ct, exp_ct);
         end
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips_c1();
      test_appendix_b();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_round();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
